// File: rtl/dct_seq_pkg.sv
// rtl/dct_seq_pkg.sv - shared state type, constants and helpers for the DCT tile sequencer
// Purpose: FSM state enum, block size constant, window slot mapping and frame block count.
// Ports: none (package).
package dct_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    localparam int BLK_PIX = 64;

    // Pixel/coefficient k of a block lives in word (63-k) of the flat bus.
    function automatic logic [5:0] slot_of(input logic [5:0] k);
        return 6'd63 - k;
    endfunction

    function automatic int blocks_per_frame(input int img_w, input int img_h);
        return (img_w / 8) * (img_h / 8);
    endfunction

endpackage

// File: rtl/dct_seq_capture.sv
// rtl/dct_seq_capture.sv - 64xN coefficient capture register with indexed read mux
// Purpose: snapshots the dct2d coefficient bus once per block and serves one word per index.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_cap_en      load i_coef into the capture register this edge
//   i_coef        flat coefficient bus, coefficient k at bits [(63-k)*N +: N]
//   i_rd_idx      row-major coefficient index to present
//   o_rd_data     captured coefficient i_rd_idx
module dct_seq_capture
    import dct_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cap_en,
    input  logic [N*BLK_PIX-1:0] i_coef,
    input  logic [5:0]           i_rd_idx,
    output logic [N-1:0]         o_rd_data
);

    logic [N*BLK_PIX-1:0] r_cap;
    logic [N-1:0]         w_slots [BLK_PIX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= '0;
        end else if (i_cap_en) begin
            r_cap <= i_coef;
        end
    end

    for (genvar j = 0; j < BLK_PIX; j++) begin : g_slot
        assign w_slots[j] = r_cap[j*N +: N];
    end

    assign o_rd_data = w_slots[slot_of(i_rd_idx)];

endmodule

// File: rtl/dct_tile_sequencer.sv
// rtl/dct_tile_sequencer.sv - frame-level load/settle/drain controller for the 8x8 dct2d datapath
// Purpose: packs 64-pixel blocks into the dct2d window, waits DCT_LAT cycles, captures the
//   coefficients and streams them out row-major with valid/ready, counting blocks per frame.
// Optional feature: DCT_SEQ_OVERLAP_EN adds a second load buffer so the next block loads
//   during SETTLE/DRAIN of the current one.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start, busy                    frame start (IDLE only), not-IDLE indicator
//   pix_valid/pix_ready/pix_data   block-ordered pixel input stream
//   dct_win, dct_coef              window to / coefficients from dct2d
//   coef_valid/coef_ready/coef_data/coef_last   coefficient output stream
//   block_idx, frame_done          current block index, end-of-frame pulse
module dct_tile_sequencer
    import dct_seq_pkg::*;
#(
    parameter int N       = 16,
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int DCT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [N-1:0]         pix_data,
    output logic [N*BLK_PIX-1:0] dct_win,
    input  logic [N*BLK_PIX-1:0] dct_coef,
    output logic                 coef_valid,
    input  logic                 coef_ready,
    output logic [N-1:0]         coef_data,
    output logic                 coef_last,
    output logic [15:0]          block_idx,
    output logic                 frame_done
);

    localparam int              SW          = (DCT_LAT < 1) ? 1 : $clog2(DCT_LAT + 1);
    localparam logic [SW-1:0]   SETTLE_INIT = SW'(DCT_LAT);
    localparam logic [15:0]     LAST_BLK    = 16'(blocks_per_frame(IMG_W, IMG_H) - 1);

    seq_state_t    r_state;
    logic [5:0]    r_k;
    logic [5:0]    r_c;
    logic [SW-1:0] r_cnt;
    logic          r_busy;
    logic          r_coef_valid;
    logic          r_coef_last;
    logic          r_frame_done;
    logic [15:0]   r_block_idx;
    logic [N-1:0]  r_win [BLK_PIX];

    logic          w_pix_fire;
    logic          w_coef_fire;
    logic          w_cap_en;

`ifdef DCT_SEQ_OVERLAP_EN
    localparam logic [16:0] TOTAL_BLK = 17'(blocks_per_frame(IMG_W, IMG_H));

    logic [N-1:0]  r_lbuf [BLK_PIX];
    logic          r_lbuf_full;
    logic [16:0]   r_loaded;

    // Loading runs independently of the drain; it only pauses while a full block waits
    // for the window and stops once every block of the frame has been taken in.
    assign pix_ready = r_busy && !r_lbuf_full && (r_loaded != TOTAL_BLK);
`else
    logic          r_pix_ready;

    assign pix_ready = r_pix_ready;
`endif

    assign w_pix_fire  = pix_valid && pix_ready;
    assign w_coef_fire = r_coef_valid && coef_ready;
    // The settle counter has already spent DCT_LAT cycles when it sits at zero.
    assign w_cap_en    = (r_state == SETTLE) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_c          <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_coef_valid <= 1'b0;
            r_coef_last  <= 1'b0;
            r_frame_done <= 1'b0;
            r_block_idx  <= '0;
            for (int j = 0; j < BLK_PIX; j++) begin
                r_win[j] <= '0;
            end
`ifdef DCT_SEQ_OVERLAP_EN
            for (int j = 0; j < BLK_PIX; j++) begin
                r_lbuf[j] <= '0;
            end
            r_lbuf_full <= 1'b0;
            r_loaded    <= '0;
`else
            r_pix_ready <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;

`ifdef DCT_SEQ_OVERLAP_EN
            if (w_pix_fire) begin
                r_lbuf[slot_of(r_k)] <= pix_data;
                r_k                  <= r_k + 6'd1;
                if (r_k == 6'd63) begin
                    r_lbuf_full <= 1'b1;
                    r_loaded    <= r_loaded + 17'd1;
                end
            end
`endif

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= LOAD;
                        r_busy      <= 1'b1;
                        r_block_idx <= '0;
                        r_k         <= '0;
                        r_c         <= '0;
`ifdef DCT_SEQ_OVERLAP_EN
                        r_lbuf_full <= 1'b0;
                        r_loaded    <= '0;
`else
                        r_pix_ready <= 1'b1;
`endif
                    end
                end

                LOAD: begin
`ifdef DCT_SEQ_OVERLAP_EN
                    if (r_lbuf_full) begin
                        r_win       <= r_lbuf;
                        r_lbuf_full <= 1'b0;
                        r_cnt       <= SETTLE_INIT;
                        r_state     <= SETTLE;
                    end
`else
                    if (w_pix_fire) begin
                        r_win[slot_of(r_k)] <= pix_data;
                        r_k                 <= r_k + 6'd1;
                        if (r_k == 6'd63) begin
                            r_pix_ready <= 1'b0;
                            r_cnt       <= SETTLE_INIT;
                            r_state     <= SETTLE;
                        end
                    end
`endif
                end

                SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state      <= DRAIN;
                        r_coef_valid <= 1'b1;
                        r_coef_last  <= 1'b0;
                        r_c          <= '0;
                    end else begin
                        r_cnt <= r_cnt - SW'(1);
                    end
                end

                DRAIN: begin
                    if (w_coef_fire) begin
                        r_c         <= r_c + 6'd1;
                        r_coef_last <= (r_c == 6'd62);
                        if (r_c == 6'd63) begin
                            r_coef_valid <= 1'b0;
                            r_coef_last  <= 1'b0;
                            if (r_block_idx == LAST_BLK) begin
                                r_state      <= IDLE;
                                r_busy       <= 1'b0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_block_idx <= r_block_idx + 16'd1;
`ifdef DCT_SEQ_OVERLAP_EN
                                // Next block already buffered: hand it to the datapath now.
                                if (r_lbuf_full) begin
                                    r_win       <= r_lbuf;
                                    r_lbuf_full <= 1'b0;
                                    r_cnt       <= SETTLE_INIT;
                                    r_state     <= SETTLE;
                                end else begin
                                    r_state <= LOAD;
                                end
`else
                                r_state     <= LOAD;
                                r_pix_ready <= 1'b1;
`endif
                            end
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < BLK_PIX; j++) begin : g_win
        assign dct_win[j*N +: N] = r_win[j];
    end

    dct_seq_capture #(
        .N (N)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .i_cap_en  (w_cap_en),
        .i_coef    (dct_coef),
        .i_rd_idx  (r_c),
        .o_rd_data (coef_data)
    );

    assign busy       = r_busy;
    assign coef_valid = r_coef_valid;
    assign coef_last  = r_coef_last;
    assign block_idx  = r_block_idx;
    assign frame_done = r_frame_done;

endmodule
